// File: rtl/sram_controller_pkg.sv
// Shared encodings and widths for the SRAM controller and its read buffer.
package sram_defs;
  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;
  localparam logic [31:0] DATA_BASE_DEF = 32'd1024;
  localparam int SRAM_DW = 16;
  localparam int SRAM_AW = 18;
  localparam int MEM_DW  = 32;
endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM controller: request, data and completion/stall.
interface sram_controller_if;
  import sram_defs::*;
  logic              wr_en;
  logic              rd_en;
  logic [MEM_DW-1:0] address;
  logic [MEM_DW-1:0] write_data;
  logic [MEM_DW-1:0] read_data;
  logic              ready;
  logic              SRAM_freeze;
  modport master (output wr_en, rd_en, address, write_data,
                  input  read_data, ready, SRAM_freeze);
  modport slave  (input  wr_en, rd_en, address, write_data,
                  output read_data, ready, SRAM_freeze);
endinterface

// File: rtl/sram_controller_read_cache.sv
// One-entry read buffer: filled by every completed read, kept coherent on writes.
module sram_read_cache
  import sram_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [MEM_DW-1:0] address,
  input  logic [MEM_DW-1:0] write_data,
  input  logic [MEM_DW-1:0] read_data,
  input  logic              fill,
  input  logic              wr_done,
  output logic              hit,
  output logic [MEM_DW-1:0] data
);
  logic              valid;
  logic [MEM_DW-1:0] tag;

  assign hit = valid && (tag == address);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= address;
      data  <= read_data;
    end else if (wr_done && hit) begin
      data  <= write_data;
    end
  end
endmodule

// File: rtl/sram_controller.sv
// Splits a 32-bit load/store into two halfword accesses on a 16-bit async SRAM.
// Optional one-entry read buffer is built when SRAM_READ_CACHE_EN is defined.
module sram_controller
  import sram_defs::*;
#(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] DATA_BASE     = DATA_BASE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   bus,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);
  localparam int            CW   = $clog2(ACCESS_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  state_t               state, nxt;
  logic [CW-1:0]        cnt;
  logic                 op_wr;
  logic                 in_phase;
  logic                 phase_end;
  logic [16:0]          word;
  logic [SRAM_AW-1:0]   addr_nxt;
  logic [SRAM_DW-1:0]   dq_out;
  logic                 dq_oe;

  assign word      = 17'((bus.address - DATA_BASE) >> 2);
  assign in_phase  = (state == LOW) || (state == HIGH);
  assign phase_end = in_phase && (cnt == LAST);

  assign bus.ready       = (state == DONE);
  assign bus.SRAM_freeze = (bus.wr_en | bus.rd_en) & ~bus.ready;

`ifdef SRAM_READ_CACHE_EN
  logic              hit, hit_wait;
  logic [MEM_DW-1:0] cache_data;

  sram_read_cache u_cache (
    .clk        (clk),
    .rst        (rst),
    .address    (bus.address),
    .write_data (bus.write_data),
    .read_data  (bus.read_data),
    .fill       ((state == DONE) && !op_wr),
    .wr_done    ((state == DONE) && op_wr),
    .hit        (hit),
    .data       (cache_data)
  );
`endif

  always_comb begin
    nxt      = state;
    addr_nxt = SRAM_ADDR;
    case (state)
      IDLE: begin
        if (bus.wr_en) nxt = LOW;
        else if (bus.rd_en) begin
`ifdef SRAM_READ_CACHE_EN
          // a hit spends one extra IDLE clock so it answers two clocks after the request
          if (!hit)         nxt = LOW;
          else if (hit_wait) nxt = DONE;
`else
          nxt = LOW;
`endif
        end
      end
      LOW:     if (phase_end) nxt = HIGH;
      HIGH:    if (phase_end) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (nxt == LOW  && state != LOW)  addr_nxt = {word, 1'b0};
    if (nxt == HIGH && state != HIGH) addr_nxt = {word, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      op_wr         <= 1'b0;
      SRAM_ADDR     <= '0;
      bus.read_data <= '0;
    end else begin
      state     <= nxt;
      SRAM_ADDR <= addr_nxt;
      cnt       <= (in_phase && !phase_end) ? cnt + CW'(1) : '0;
      if (state == IDLE) op_wr <= bus.wr_en;
      // the last clock of each read phase gives the SRAM its full access time
      if (phase_end && !op_wr) begin
        if (state == LOW)  bus.read_data[15:0]  <= SRAM_DQ;
        if (state == HIGH) bus.read_data[31:16] <= SRAM_DQ;
      end
`ifdef SRAM_READ_CACHE_EN
      if (state == IDLE && nxt == DONE) bus.read_data <= cache_data;
`endif
    end
  end

`ifdef SRAM_READ_CACHE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hit_wait <= 1'b0;
    else      hit_wait <= (state == IDLE) && bus.rd_en && !bus.wr_en && hit && !hit_wait;
  end
`endif

  // WE_N rises on the last clock of a write phase while address and data stay put
  assign SRAM_WE_N = !(op_wr && in_phase && !phase_end);
  assign dq_oe     = op_wr && in_phase;
  assign dq_out    = (state == HIGH) ? bus.write_data[31:16] : bus.write_data[15:0];
  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
endmodule
